// File: rtl/dmem_stream_reader.sv
// rtl/dmem_stream_reader.sv - block reader for data memory port 1, streams words out as bytes
//
// Fetches word_count consecutive words starting at base_addr[11:2] and emits
// each word as four bytes over a valid/ready handshake. One byte per cycle is
// sustained: the next word is loaded on the same edge that accepts the last
// byte of the current one.
//
// Build option: define DMEM_READER_BIG_ENDIAN_EN to emit each word MSB first.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle request, ignored while a block is in progress
//   base_addr         starting byte address (bits [11:2] used)
//   word_count        words to read, 0..1024
//   rd_addr, rd_data  memory read port (combinational read data)
//   m_valid, m_data,
//   m_last, m_ready   byte stream out
//   busy, done        status; done is a one-cycle completion pulse
module dmem_stream_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [10:0] word_count,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [9:0]  idx;
  logic [10:0] remaining;
  logic [31:0] word_buf;
  logic [1:0]  byte_sel;
  // Set when DONE was reached from an empty request; such a request never
  // makes the block look busy.
  logic        empty_blk;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{base_addr[31:12], base_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 10'd0;
      remaining <= 11'd0;
      word_buf  <= 32'd0;
      byte_sel  <= 2'd0;
      empty_blk <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != 11'd0) begin
              idx       <= base_addr[11:2];
              remaining <= word_count;
              empty_blk <= 1'b0;
              state     <= FETCH;
            end else begin
              empty_blk <= 1'b1;
              state     <= DONE;
            end
          end
        end
        FETCH: begin
          word_buf  <= rd_data;
          idx       <= idx + 10'd1;
          remaining <= remaining - 11'd1;
          byte_sel  <= 2'd0;
          state     <= STREAM;
        end
        STREAM: begin
          if (m_ready) begin
            if (byte_sel != 2'd3) begin
              byte_sel <= byte_sel + 2'd1;
            end else if (remaining != 11'd0) begin
              // Reload on the final-byte handshake so no bubble appears.
              word_buf  <= rd_data;
              idx       <= idx + 10'd1;
              remaining <= remaining - 11'd1;
              byte_sel  <= 2'd0;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          empty_blk <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // idx always points at the next word to fetch, so rd_addr depends only on
  // registers and never on rd_data.
  assign rd_addr = {20'd0, idx, 2'b00};

  assign m_valid = (state == STREAM);
  assign m_last  = (state == STREAM) && (byte_sel == 2'd3) && (remaining == 11'd0);
  assign busy    = (state == FETCH) || (state == STREAM) || ((state == DONE) && !empty_blk);
  assign done    = (state == DONE);

  logic [7:0] sel_byte;
  always_comb begin
    sel_byte = 8'd0;
`ifdef DMEM_READER_BIG_ENDIAN_EN
    case (byte_sel)
      2'd0: sel_byte = word_buf[31:24];
      2'd1: sel_byte = word_buf[23:16];
      2'd2: sel_byte = word_buf[15:8];
      2'd3: sel_byte = word_buf[7:0];
      default: sel_byte = 8'd0;
    endcase
`else
    case (byte_sel)
      2'd0: sel_byte = word_buf[7:0];
      2'd1: sel_byte = word_buf[15:8];
      2'd2: sel_byte = word_buf[23:16];
      2'd3: sel_byte = word_buf[31:24];
      default: sel_byte = 8'd0;
    endcase
`endif
  end

  // Payload reads as zero whenever no byte is offered.
  assign m_data = m_valid ? sel_byte : 8'd0;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// tb/tb_dmem_stream_reader.sv - randomized self-checking bench for dmem_stream_reader
module tb_dmem_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [10:0] word_count;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  assign rd_data = mem[rd_addr[11:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected byte list for a block, straight from the memory image.
  task automatic build_expect(input logic [31:0] base, input int cnt, output logic [7:0] q[$]);
    int bw;
    logic [31:0] w;
    q = {};
    bw = int'(base[11:2]);
    for (int i = 0; i < cnt; i++) begin
      w = mem[(bw + i) % 1024];
      for (int b = 0; b < 4; b++) begin
`ifdef DMEM_READER_BIG_ENDIAN_EN
        q.push_back(8'((w >> (8 * (3 - b))) & 32'hFF));
`else
        q.push_back(8'((w >> (8 * b)) & 32'hFF));
`endif
      end
    end
  endtask

  // mode 0: ready always high; 1: ready alternating; 2: random ready plus
  // stray start pulses that must be ignored.
  task automatic run_block(input logic [31:0] base, input int cnt, input int mode);
    logic [7:0]  exp_q[$];
    int          bw, total, k, vcyc, limit;
    bit          last_hs, seen_done, stalled;
    logic [7:0]  prev_data;
    logic [31:0] prev_addr;

    build_expect(base, cnt, exp_q);
    bw    = int'(base[11:2]);
    total = cnt * 4;

    start      = 1'b1;
    base_addr  = base;
    word_count = 11'(cnt);
    m_ready    = 1'b0;
    step;
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = 11'($urandom);

    if (cnt == 0) begin
      check("empty_done", done, 1);
      check("empty_busy", busy, 0);
      check("empty_valid", m_valid, 0);
      step;
      check("empty_done_clr", done, 0);
      check("empty_valid2", m_valid, 0);
      check("empty_busy2", busy, 0);
      return;
    end

    check("fetch_busy", busy, 1);
    check("fetch_valid", m_valid, 0);
    check("fetch_done", done, 0);
    check("fetch_addr", rd_addr, 32'((bw % 1024) * 4));

    k = 0; vcyc = 0; last_hs = 0; seen_done = 0; stalled = 0;
    prev_data = 8'd0; prev_addr = 32'd0;
    limit = total * 20 + 20;
    for (int cyc = 0; cyc < limit && !seen_done; cyc++) begin
      step;
      if (done) begin
        check("done_after_last", 32'(last_hs), 1);
        check("done_busy", busy, 1);
        check("done_valid", m_valid, 0);
        seen_done = 1;
      end else begin
        last_hs = 0;
        check("valid", m_valid, 32'(k < total));
        if (m_valid && k < total) begin
          vcyc++;
          if (stalled) begin
            check("stall_data", m_data, prev_data);
            check("stall_addr", rd_addr, prev_addr);
          end
          check("data", m_data, exp_q[k]);
          check("last", m_last, 32'(k == total - 1));
          check("stream_addr", rd_addr, 32'(((bw + k / 4 + 1) % 1024) * 4));
          check("stream_busy", busy, 1);
          case (mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 2) == 1;
            default: m_ready = 1'($urandom_range(0, 1));
          endcase
          if (mode == 2) begin
            start      = 1'($urandom_range(0, 1));
            base_addr  = $urandom;
            word_count = 11'($urandom);
          end
          prev_data = m_data;
          prev_addr = rd_addr;
          stalled   = !m_ready;
          if (m_ready) begin
            k++;
            last_hs = (k == total);
          end
        end
      end
    end
    start   = 1'b0;
    m_ready = 1'b0;
    check("done_seen", 32'(seen_done), 1);
    check("byte_count", k, total);
    if (mode == 0) check("stream_cycles", vcyc, total);
    step;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic reset_mid_block;
    start = 1'b1; base_addr = 32'h0; word_count = 11'd3; m_ready = 1'b1;
    step;                          // FETCH
    start = 1'b0;
    step;                          // byte 0 offered and taken
    check("rst_b0", m_data, 8'h11);
    start = 1'b1; word_count = 11'd0; base_addr = 32'h800;
    step;                          // byte 1; the start above is ignored
    start = 1'b0;
    check("rst_b1", m_data, 8'h22);
    check("rst_nodone", done, 0);
    step;                          // byte 2
    check("rst_b2", m_data, 8'h33);
    rst_n = 1'b0;
    step;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_done", done, 0);
    check("rst_data", m_data, 0);
    rst_n = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      check("rst_quiet_done", done, 0);
      check("rst_quiet_valid", m_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]    = 32'h44332211;
    mem[1]    = 32'h88776655;
    mem[1023] = 32'hDDCCBBAA;

    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; word_count = 11'd0; m_ready = 1'b0;
    step;
    step;
    check("reset_valid", m_valid, 0);
    check("reset_data", m_data, 0);
    check("reset_last", m_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", rd_addr, 0);
    rst_n = 1'b1;
    step;

    run_block(32'h0, 2, 0);
    run_block(32'h0, 2, 1);
    run_block(32'h0000_0FFC, 2, 0);
    run_block(32'h0, 0, 0);
    reset_mid_block();
    run_block(32'h0, 1, 0);
    run_block(32'hFFFF_F003, 3, 2);
    for (int t = 0; t < 10; t++)
      run_block($urandom, $urandom_range(1, 12), $urandom_range(0, 2));
    run_block($urandom, 1024, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
